// File: rtl/dff_input_debounce.sv
// Input debounce stage feeding the d-flip-flop datapath.
// A raw, possibly bouncing input is passed through a SYNC_STAGES-deep synchroniser.
// The synchronised level s must be seen on STABLE_CYCLES consecutive edges before the
// debounced level q changes. The rise and fall outputs are one-cycle strobes that mark
// each change of q.
// Optional feature: define DEBOUNCE_GLITCH_CNT_EN to add a saturating 8-bit glitch_cnt
// output that counts rejected pulses.
// Reset is synchronous and active-low on rstn.

module dff_input_debounce #(
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       din,
   output logic       q,
   output logic       rise,
   output logic       fall
`ifdef DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [7:0] glitch_cnt
`endif
);

   // Parameters outside the legal range are flagged at elaboration.
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("dff_input_debounce: SYNC_STAGES must be in 2..4");
   end
   if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
      $error("dff_input_debounce: STABLE_CYCLES must be in 2..255");
   end

   // The terminal count is one less than STABLE_CYCLES. The edge that enters a wait
   // state already counts as the first stable sample.
   localparam logic [7:0] CntMax = 8'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      st_idle_low  = 2'b00,
      st_wait_high = 2'b01,
      st_idle_high = 2'b10,
      st_wait_low  = 2'b11
   } state_e;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;

   state_e                 state_q, state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   q_q, q_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Synchroniser chain: din enters bit 0, and the top bit is the synchronised level.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // State, stable-sample counter, debounced level and strobe registers.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= st_idle_low;
         cnt_q   <= 8'd0;
         q_q     <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next-state logic: any sample that matches the current level during a wait cancels it.
   // The count then restarts from the idle state, so a partial count is never carried over.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      unique case (state_q)
         st_idle_low: begin
            q_d = 1'b0;
            if (s) begin
               state_d = st_wait_high;
               cnt_d   = 8'd1;
            end
         end

         st_wait_high: begin
            q_d = 1'b0;
            if (!s) begin
               state_d = st_idle_low;
               cnt_d   = 8'd0;
            end else if (cnt_q == CntMax) begin
               state_d = st_idle_high;
               cnt_d   = 8'd0;
               q_d     = 1'b1;
               rise_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         st_idle_high: begin
            q_d = 1'b1;
            if (!s) begin
               state_d = st_wait_low;
               cnt_d   = 8'd1;
            end
         end

         st_wait_low: begin
            q_d = 1'b1;
            if (s) begin
               state_d = st_idle_high;
               cnt_d   = 8'd0;
            end else if (cnt_q == CntMax) begin
               state_d = st_idle_low;
               cnt_d   = 8'd0;
               q_d     = 1'b0;
               fall_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         default: begin
            state_d = st_idle_low;
            cnt_d   = 8'd0;
            q_d     = 1'b0;
         end
      endcase
   end

   assign q    = q_q;
   assign rise = rise_q;
   assign fall = fall_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
   logic       glitch_evt;
   logic [7:0] glitch_q, glitch_d;

   // Detect a rejection: an abandoned wait in either direction.
   always_comb begin
      glitch_evt = ((state_q == st_wait_high) && !s) || ((state_q == st_wait_low) && s);
   end

   // Next value of the glitch counter, which holds at 8'hFF instead of wrapping.
   always_comb begin
      glitch_d = glitch_q;
      if (glitch_evt && (glitch_q != 8'hFF)) begin
         glitch_d = glitch_q + 8'd1;
      end
   end

   // Glitch counter register.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         glitch_q <= 8'd0;
      end else begin
         glitch_q <= glitch_d;
      end
   end

   assign glitch_cnt = glitch_q;
`endif

endmodule
